// File: rtl/control_decode_stage.sv
// rtl/control_decode_stage.sv - RV32I decode stage with ID/EX register, load-use bubbles and flush
// Decodes one instruction into a control bundle and registers it behind a valid/ready handshake.
module control_decode_stage #(
  parameter int XLEN  = 32,
  parameter int M_EXT = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             out_valid,
  output logic [XLEN-1:0]  pc_out,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       fun3,
  output logic             reg_write,
  output logic             load,
  output logic             store,
  output logic             mem_en,
  output logic             branch,
  output logic             jal,
  output logic             jalr,
  output logic             operand_a,
  output logic             operand_b,
  output logic [1:0]       mem_to_reg,
  output logic [2:0]       imm_sel,
  output logic [4:0]       alu_control,
  output logic             illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_SUB   = 5'b00001;
  localparam logic [4:0] ALU_SLL   = 5'b00010;
  localparam logic [4:0] ALU_SLT   = 5'b00011;
  localparam logic [4:0] ALU_SLTU  = 5'b00100;
  localparam logic [4:0] ALU_XOR   = 5'b00101;
  localparam logic [4:0] ALU_SRL   = 5'b00110;
  localparam logic [4:0] ALU_SRA   = 5'b00111;
  localparam logic [4:0] ALU_OR    = 5'b01000;
  localparam logic [4:0] ALU_AND   = 5'b01001;
  localparam logic [4:0] ALU_PASSB = 5'b01111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      fun3;
    logic            reg_write;
    logic            load;
    logic            store;
    logic            mem_en;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic            operand_a;
    logic            operand_b;
    logic [1:0]      mem_to_reg;
    logic [2:0]      imm_sel;
    logic [4:0]      alu_control;
    logic            illegal;
  } bundle_t;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] base_alu;
  logic       uses_rs1;
  logic       uses_rs2;
  bundle_t    dec;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    base_alu = ALU_ADD;
    case (f3)
      3'b000:  base_alu = ALU_ADD;
      3'b001:  base_alu = ALU_SLL;
      3'b010:  base_alu = ALU_SLT;
      3'b011:  base_alu = ALU_SLTU;
      3'b100:  base_alu = ALU_XOR;
      3'b101:  base_alu = ALU_SRL;
      3'b110:  base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  end

  always_comb begin
    dec      = '0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    dec.pc   = pc_in;
    dec.rs1  = instr[19:15];
    dec.rs2  = instr[24:20];
    dec.fun3 = f3;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        uses_rs2      = 1'b1;
        if (f7 == 7'b0000000) begin
          dec.alu_control = base_alu;
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          dec.alu_control = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
        end else if (f7 == 7'b0000001 && M_EXT != 0) begin
          dec.alu_control = {2'b10, f3};
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_I: begin
        dec.reg_write   = 1'b1;
        dec.operand_b   = 1'b1;
        dec.imm_sel     = IMM_I;
        dec.alu_control = (f3 == 3'b101 && instr[30]) ? ALU_SRA : base_alu;
      end
      OP_LOAD: begin
        dec.load       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = WB_MEM;
        dec.operand_b  = 1'b1;
        dec.imm_sel    = IMM_I;
        dec.illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        uses_rs2      = 1'b1;
        dec.store     = 1'b1;
        dec.mem_en    = 1'b1;
        dec.operand_b = 1'b1;
        dec.imm_sel   = IMM_S;
        dec.illegal   = (f3 > 3'b010);
      end
      OP_BRANCH: begin
        uses_rs2      = 1'b1;
        dec.branch    = 1'b1;
        dec.operand_a = 1'b1;
        dec.operand_b = 1'b1;
        dec.imm_sel   = IMM_B;
      end
      OP_JAL: begin
        uses_rs1       = 1'b0;
        dec.jal        = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = WB_PC4;
        dec.operand_a  = 1'b1;
        dec.operand_b  = 1'b1;
        dec.imm_sel    = IMM_J;
      end
      OP_JALR: begin
        dec.jalr       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = WB_PC4;
        dec.operand_b  = 1'b1;
        dec.imm_sel    = IMM_I;
      end
      OP_LUI: begin
        uses_rs1        = 1'b0;
        dec.reg_write   = 1'b1;
        dec.operand_b   = 1'b1;
        dec.imm_sel     = IMM_U;
        dec.alu_control = ALU_PASSB;
      end
      OP_AUIPC: begin
        uses_rs1      = 1'b0;
        dec.reg_write = 1'b1;
        dec.operand_a = 1'b1;
        dec.operand_b = 1'b1;
        dec.imm_sel   = IMM_U;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal instructions still travel down the pipe but must have no architectural side effect.
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_en    = 1'b0;
      dec.load      = 1'b0;
      dec.store     = 1'b0;
      dec.branch    = 1'b0;
      dec.jal       = 1'b0;
      dec.jalr      = 1'b0;
    end
    dec.rd = dec.reg_write ? instr[11:7] : 5'd0;
  end

  logic             valid_q, valid_d;
  bundle_t          bun_q, bun_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  logic             advance;

  assign hazard = in_valid && valid_q && bun_q.load && (bun_q.rd != 5'd0) &&
                  ((uses_rs1 && instr[19:15] == bun_q.rd) ||
                   (uses_rs2 && instr[24:20] == bun_q.rd));
  assign advance  = !valid_q || ex_ready;
  assign in_ready = flush || (advance && !hazard);

  always_comb begin
    valid_d = valid_q;
    bun_d   = bun_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      bun_d   = '0;
    end else if (advance) begin
      if (hazard) begin
        valid_d = 1'b0;
        bun_d   = '0;
        cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
      end else if (in_valid) begin
        valid_d = 1'b1;
        bun_d   = dec;
      end else begin
        valid_d = 1'b0;
        bun_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      bun_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      bun_q   <= bun_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign pc_out      = bun_q.pc;
  assign rd          = bun_q.rd;
  assign rs1         = bun_q.rs1;
  assign rs2         = bun_q.rs2;
  assign fun3        = bun_q.fun3;
  assign reg_write   = bun_q.reg_write;
  assign load        = bun_q.load;
  assign store       = bun_q.store;
  assign mem_en      = bun_q.mem_en;
  assign branch      = bun_q.branch;
  assign jal         = bun_q.jal;
  assign jalr        = bun_q.jalr;
  assign operand_a   = bun_q.operand_a;
  assign operand_b   = bun_q.operand_b;
  assign mem_to_reg  = bun_q.mem_to_reg;
  assign imm_sel     = bun_q.imm_sel;
  assign alu_control = bun_q.alu_control;
  assign illegal     = bun_q.illegal;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_control_decode_stage.sv
// tb/tb_control_decode_stage.sv - directed bench for control_decode_stage against a decode model
// Two instances share stimulus: A has M_EXT=1, CNT_W=16; B has M_EXT=0, CNT_W=2.
module tb_control_decode_stage;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        rw, ld, st, me, br, jal, jalr, oa, ob;
    logic [1:0]  m2r;
    logic [2:0]  imm;
    logic [4:0]  alu;
    logic        ill;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, ex_ready;
  logic [31:0] instr, pc_in;

  logic        in_ready_a, out_valid_a, reg_write_a, load_a, store_a, mem_en_a, branch_a;
  logic        jal_a, jalr_a, operand_a_a, operand_b_a, illegal_a;
  logic [31:0] pc_out_a;
  logic [4:0]  rd_a, rs1_a, rs2_a, alu_control_a;
  logic [2:0]  fun3_a, imm_sel_a;
  logic [1:0]  mem_to_reg_a;
  logic [15:0] bubble_cnt_a;

  logic        in_ready_b, out_valid_b, reg_write_b, load_b, store_b, mem_en_b, branch_b;
  logic        jal_b, jalr_b, operand_a_b, operand_b_b, illegal_b;
  logic [31:0] pc_out_b;
  logic [4:0]  rd_b, rs1_b, rs2_b, alu_control_b;
  logic [2:0]  fun3_b, imm_sel_b;
  logic [1:0]  mem_to_reg_b;
  logic [1:0]  bubble_cnt_b;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  always #5 clk = ~clk;

  control_decode_stage #(.XLEN(32), .M_EXT(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .instr(instr),
    .pc_in(pc_in), .flush(flush), .ex_ready(ex_ready), .out_valid(out_valid_a),
    .pc_out(pc_out_a), .rd(rd_a), .rs1(rs1_a), .rs2(rs2_a), .fun3(fun3_a),
    .reg_write(reg_write_a), .load(load_a), .store(store_a), .mem_en(mem_en_a),
    .branch(branch_a), .jal(jal_a), .jalr(jalr_a), .operand_a(operand_a_a),
    .operand_b(operand_b_a), .mem_to_reg(mem_to_reg_a), .imm_sel(imm_sel_a),
    .alu_control(alu_control_a), .illegal(illegal_a), .bubble_cnt(bubble_cnt_a)
  );

  control_decode_stage #(.XLEN(32), .M_EXT(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .instr(instr),
    .pc_in(pc_in), .flush(flush), .ex_ready(ex_ready), .out_valid(out_valid_b),
    .pc_out(pc_out_b), .rd(rd_b), .rs1(rs1_b), .rs2(rs2_b), .fun3(fun3_b),
    .reg_write(reg_write_b), .load(load_b), .store(store_b), .mem_en(mem_en_b),
    .branch(branch_b), .jal(jal_b), .jalr(jalr_b), .operand_a(operand_a_b),
    .operand_b(operand_b_b), .mem_to_reg(mem_to_reg_b), .imm_sel(imm_sel_b),
    .alu_control(alu_control_b), .illegal(illegal_b), .bubble_cnt(bubble_cnt_b)
  );

  bundle_t act_a, act_b, mod_a, mod_b;
  int      cnt_a, cnt_b;

  assign act_a = {out_valid_a, pc_out_a, rd_a, rs1_a, rs2_a, fun3_a, reg_write_a, load_a,
                  store_a, mem_en_a, branch_a, jal_a, jalr_a, operand_a_a, operand_b_a,
                  mem_to_reg_a, imm_sel_a, alu_control_a, illegal_a};
  assign act_b = {out_valid_b, pc_out_b, rd_b, rs1_b, rs2_b, fun3_b, reg_write_b, load_b,
                  store_b, mem_en_b, branch_b, jal_b, jalr_b, operand_a_b, operand_b_b,
                  mem_to_reg_b, imm_sel_b, alu_control_b, illegal_b};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ALU code of each fun3 slot; SUB and SRA sit one above ADD and SRL.
  function automatic bundle_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                           input bit mext);
    bundle_t    b;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         alu_base [8];
    alu_base = '{0, 2, 3, 4, 5, 6, 8, 9};
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    b = '0;
    b.v = 1'b1; b.pc = pc; b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.f3 = f3;
    case (op)
      7'h33: begin
        b.rw = 1'b1;
        if (f7 == 7'h00) b.alu = 5'(alu_base[f3]);
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) b.alu = 5'(alu_base[f3] + 1);
        else if (f7 == 7'h01 && mext) b.alu = 5'(16 + int'(f3));
        else b.ill = 1'b1;
      end
      7'h13: begin
        b.rw = 1'b1; b.ob = 1'b1; b.imm = 3'd0;
        b.alu = 5'(alu_base[f3] + ((f3 == 3'd5 && ins[30]) ? 1 : 0));
      end
      7'h03: begin
        b.ld = 1'b1; b.rw = 1'b1; b.m2r = 2'd1; b.ob = 1'b1; b.imm = 3'd0;
        b.ill = (f3 == 3'd3 || f3 >= 3'd6);
      end
      7'h23: begin
        b.st = 1'b1; b.me = 1'b1; b.ob = 1'b1; b.imm = 3'd1; b.ill = (f3 > 3'd2);
      end
      7'h63: begin b.br = 1'b1; b.oa = 1'b1; b.ob = 1'b1; b.imm = 3'd2; end
      7'h6F: begin b.jal = 1'b1; b.rw = 1'b1; b.m2r = 2'd2; b.oa = 1'b1; b.ob = 1'b1; b.imm = 3'd3; end
      7'h67: begin b.jalr = 1'b1; b.rw = 1'b1; b.m2r = 2'd2; b.ob = 1'b1; b.imm = 3'd0; end
      7'h37: begin b.rw = 1'b1; b.ob = 1'b1; b.imm = 3'd4; b.alu = 5'd15; end
      7'h17: begin b.rw = 1'b1; b.oa = 1'b1; b.ob = 1'b1; b.imm = 3'd4; end
      default: b.ill = 1'b1;
    endcase
    if (b.ill) begin
      b.rw = 0; b.me = 0; b.ld = 0; b.st = 0; b.br = 0; b.jal = 0; b.jalr = 0;
    end
    b.rd = b.rw ? ins[11:7] : 5'd0;
    return b;
  endfunction

  function automatic bit model_hazard(input bundle_t m, input logic [31:0] ins, input logic vld);
    logic [6:0] op;
    bit u1, u2;
    op = ins[6:0];
    u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
    return vld && m.v && m.ld && m.rd != 5'd0 &&
           ((u1 && ins[19:15] == m.rd) || (u2 && ins[24:20] == m.rd));
  endfunction

  always @(posedge clk) begin : model_p
    bit hz, adv;
    if (rst) begin
      mod_a = '0; mod_b = '0; cnt_a = 0; cnt_b = 0;
    end else begin
      hz  = model_hazard(mod_a, instr, in_valid);
      adv = !mod_a.v || ex_ready;
      if (flush) begin
        mod_a = '0; mod_b = '0;
      end else if (adv) begin
        if (hz) begin
          mod_a = '0; mod_b = '0;
          cnt_a = (cnt_a < 65535) ? cnt_a + 1 : cnt_a;
          cnt_b = (cnt_b < 3) ? cnt_b + 1 : cnt_b;
        end else if (in_valid) begin
          mod_a = model_decode(instr, pc_in, 1'b1);
          mod_b = model_decode(instr, pc_in, 1'b0);
        end else begin
          mod_a = '0; mod_b = '0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare_p
    bit exp_rdy;
    if (started) begin
      exp_rdy = flush || ((!mod_a.v || ex_ready) && !model_hazard(mod_a, instr, in_valid));
      chk("bundle_a", 128'(act_a), 128'(mod_a));
      chk("bundle_b", 128'(act_b), 128'(mod_b));
      chk("cnt_a", 128'(bubble_cnt_a), 128'(cnt_a));
      chk("cnt_b", 128'(bubble_cnt_b), 128'(cnt_b));
      chk("in_ready_a", 128'(in_ready_a), 128'(exp_rdy));
      chk("in_ready_b", 128'(in_ready_b), 128'(exp_rdy));
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    int n;
    bit done;
    in_valid = 1'b1; instr = ins; pc_in = pc; n = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      done = in_ready_a;
      @(posedge clk); #1;
      n++;
      if (!done && n >= 20) begin
        checks++; errors++;
        $display("FAIL send_timeout actual=stalled expected=accept instr=%h", ins);
        done = 1;
      end
    end
    in_valid = 1'b0; instr = '0; pc_in = '0;
  endtask

  logic [31:0] tab [21] = '{
    32'h4020D193, 32'h0020A223, 32'h0020B223, 32'h00208463, 32'h0002B3B7, 32'h00001397,
    32'h008000EF, 32'hFFFFFFFF, 32'h0000E283, 32'h00528333, 32'h202081B3, 32'h402091B3,
    32'h0020B1B3, 32'h0000A283, 32'h0050A023, 32'h0000A283, 32'h0002B3B7, 32'h0000A003,
    32'h00000333, 32'h0000A283, 32'h00228463
  };

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; pc_in = '0; flush = 1'b0; ex_ready = 1'b1;
    @(posedge clk);
    started = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 128'(out_valid_a), 128'(0));
    chk("rst_bubble_cnt", 128'(bubble_cnt_a), 128'(0));
    chk("rst_reg_write", 128'(reg_write_a), 128'(0));

    send(32'h002081B3, 32'h100);
    chk("add_valid", 128'(out_valid_a), 128'(1));
    chk("add_alu", 128'(alu_control_a), 128'(5'b00000));
    chk("add_rd", 128'(rd_a), 128'(3));
    chk("add_rs1", 128'(rs1_a), 128'(1));
    chk("add_rs2", 128'(rs2_a), 128'(2));
    chk("add_reg_write", 128'(reg_write_a), 128'(1));
    chk("add_operand_b", 128'(operand_b_a), 128'(0));
    send(32'h402081B3, 32'h104);
    chk("sub_alu", 128'(alu_control_a), 128'(5'b00001));

    send(32'h0000A283, 32'h108);
    in_valid = 1'b1; instr = 32'h00528333; pc_in = 32'h10C;
    @(negedge clk);
    chk("lu_stall_ready", 128'(in_ready_a), 128'(0));
    @(posedge clk); #1;
    chk("lu_bubble_valid", 128'(out_valid_a), 128'(0));
    chk("lu_bubble_cnt", 128'(bubble_cnt_a), 128'(1));
    @(negedge clk);
    chk("lu_accept_ready", 128'(in_ready_a), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lu_add_valid", 128'(out_valid_a), 128'(1));
    chk("lu_add_rd", 128'(rd_a), 128'(6));

    send(32'h000100E7, 32'h200);
    ex_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h002081B3; pc_in = 32'h204;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_jalr", 128'(jalr_a), 128'(1));
      chk("bp_m2r", 128'(mem_to_reg_a), 128'(2'b10));
      chk("bp_rd", 128'(rd_a), 128'(1));
      chk("bp_ready", 128'(in_ready_a), 128'(0));
      @(posedge clk); #1;
    end
    ex_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 128'(in_ready_a), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_pc", 128'(pc_out_a), 128'(32'h204));

    send(32'h022081B3, 32'h300);
    chk("mul_alu_a", 128'(alu_control_a), 128'(5'b10000));
    chk("mul_illegal_a", 128'(illegal_a), 128'(0));
    chk("mul_illegal_b", 128'(illegal_b), 128'(1));
    chk("mul_reg_write_b", 128'(reg_write_b), 128'(0));

    in_valid = 1'b1; instr = 32'h002081B3; pc_in = 32'h400; flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", 128'(in_ready_a), 128'(1));
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 128'(out_valid_a), 128'(0));
    chk("flush_cnt", 128'(bubble_cnt_a), 128'(1));

    for (int i = 0; i < 21; i++) send(tab[i], 32'h500 + 32'(4 * i));
    chk("table_cnt_a", 128'(bubble_cnt_a), 128'(3));

    for (int i = 0; i < 5; i++) begin
      send(32'h0000A283, 32'h600 + 32'(8 * i));
      send(32'h00528333, 32'h604 + 32'(8 * i));
    end
    chk("sat_cnt_b", 128'(bubble_cnt_b), 128'(3));
    chk("sat_cnt_a", 128'(bubble_cnt_a), 128'(8));

    send(32'h0000A283, 32'h700);
    in_valid = 1'b1; instr = 32'h00528333; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_mid_valid", 128'(out_valid_a), 128'(0));
    chk("rst_mid_cnt_a", 128'(bubble_cnt_a), 128'(0));
    chk("rst_mid_cnt_b", 128'(bubble_cnt_b), 128'(0));
    chk("rst_mid_rd", 128'(rd_a), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_decode_stage.md
Name: control_decode_stage

Overview:
- Parametrised next-generation instruction decoder for the RV32I pipeline.
- Decodes a raw 32-bit instruction into the control bundle: reg write, mem, branch/jump, operand selects, immediate select and ALU op.
- Registers the bundle into the ID/EX pipeline register using a valid/ready handshake.
- Adds flush, load-use hazard bubble insertion, illegal-instruction detection, optional M-extension decode and a saturating stall counter.

Parameters:
XLEN, 32, width of PC path.
M_EXT, 0, 1 = decode MUL/DIV/REM (opcode 0110011, fun7 0000001); 0 = treat those as illegal.
CNT_W, 16, width of the saturating bubble counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
in_valid  in  1  IF/ID holds a valid instruction.
in_ready  out  1  stage accepts the instruction this cycle.
instr  in  32  raw instruction.
pc_in  in  XLEN  PC of instr.
flush  in  1  branch/jump redirect; kill the accepted input and the output register.
ex_ready  in  1  EX stage accepts the output bundle.
out_valid  out  1  bundle valid.
pc_out  out  XLEN  registered PC.
rd, rs1, rs2  out  5 each  register indices.
fun3  out  3  registered fun3.
reg_write, load, store, mem_en, branch, jal, jalr, operand_a, operand_b  out  1 each  control flags.
mem_to_reg  out  2  00 ALU, 01 memory, 10 PC+4.
imm_sel  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
alu_control  out  5  ALU operation code.
illegal  out  1  unsupported opcode or fun3/fun7 combination.
bubble_cnt  out  CNT_W  load-use bubbles inserted, saturating.

Behaviour:
- Reset: all outputs 0, including out_valid, bubble_cnt and every control and register field.
- Latency: exactly one cycle from acceptance (in_valid & in_ready) to out_valid.
- ALU codes, base ISA:
  - 00000 ADD, 00001 SUB, 00010 SLL, 00011 SLT, 00100 SLTU.
  - 00101 XOR, 00110 SRL, 00111 SRA, 01000 OR, 01001 AND, 01111 LUI pass-B.
  - I-type, load, store, branch, JAL, JALR and AUIPC use ADD, except I-type with an ALU fun3.
  - SRAI is selected by instr[30].
- ALU codes, M extension: {2'b10, fun3}.
- Decode per opcode:
  - R-type: reg_write=1.
  - I-type: reg_write=1, operand_b=1, imm I.
  - Load: load=1, reg_write=1, mem_to_reg=01, operand_b=1, imm I.
  - Store: store=1, mem_en=1, operand_b=1, imm S.
  - Branch: branch=1, operand_a=1, operand_b=1, imm B.
  - JAL: jal=1, reg_write=1, mem_to_reg=10, operand_a=1, operand_b=1, imm J.
  - JALR: jalr=1, reg_write=1, mem_to_reg=10, operand_b=1, imm I.
  - LUI: reg_write=1, operand_b=1, imm U, alu 01111.
  - AUIPC: reg_write=1, operand_a=1, operand_b=1, imm U.
- Illegal: unknown opcode, R-type fun7 not in {0000000, 0100000 with fun3 000/101, 0000001 when M_EXT=1}, load fun3 in {011,110,111}, store fun3 >010. On illegal: illegal=1 and reg_write, mem_en, load, store, branch, jal, jalr all 0; the bundle still advances with out_valid=1.
- rd is forced to 0 in the output when reg_write=0.
- Hazard: out_valid & load & rd!=0 & ((uses_rs1 & instr rs1==rd) | (uses_rs2 & instr rs2==rd)).
  - uses_rs1: all except LUI, AUIPC, JAL.
  - uses_rs2: R-type, store, branch.
- Handshake:
  - advance = !out_valid | ex_ready.
  - in_ready = advance & !hazard, or 1 when flush.
  - While out_valid & !ex_ready, all output fields hold stable.
- Hazard with advance: the output register loads a bubble (out_valid=0, all controls 0) and bubble_cnt increments, saturating at all-ones. The next cycle the hazard is clear and the instruction is accepted.
- Flush (highest priority): next cycle out_valid=0. Any input presented that cycle is consumed and discarded. bubble_cnt is unchanged.
- rst asserted mid-stall or mid-flush: the reset state wins on the next edge.

Test Plan:
- Decode: 0x002081B3 then 0x402081B3, ex_ready=1.
  - First: out_valid next cycle, alu 00000, rd=3, rs1=1, rs2=2, reg_write=1, operand_b=0.
  - Second: alu 00001.
- Load-use: 0x0000A283 (lw x5,0(x1)) followed by 0x00528333 (add x6,x5,x5).
  - One bubble cycle with out_valid=0 and in_ready=0.
  - add emerges one cycle later.
  - bubble_cnt=1.
- Backpressure: ex_ready=0 for 3 cycles with 0x000100E7 (jalr x1,0(x2)) in the output register.
  - Outputs held: jalr=1, mem_to_reg=10, rd=1.
  - in_ready=0.
  - Released on ex_ready=1.
- M extension: 0x022081B3 with M_EXT=1 -> alu 10000, illegal=0. With M_EXT=0 -> illegal=1, reg_write=0.
- Flush: flush=1 in the same cycle as valid instr 0x002081B3 -> next cycle out_valid=0, in_ready was 1 during the flush cycle, bubble_cnt unchanged.
- Saturation: CNT_W=2, 5 load-use pairs -> bubble_cnt sticks at 3. Assert rst -> all outputs 0 on the next edge.
